// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes and an iterative unsigned multiply.
// Ports: clk, rst, in_valid/in_ready, opcode, A, B, out_valid/out_ready, result, zero/carry/overflow/sign, illegal.
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             sign,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_CMP = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;
  localparam logic [3:0] OP_SRA = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             z;
    logic             c;
    logic             v;
    logic             s;
    logic             ill;
  } out_t;

  state_t               state;
  out_t                 out_q;
  out_t                 alu_out;
  out_t                 mul_out;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_nxt;
  logic [SHW-1:0]       cnt;
  logic                 accept;

  // Single-cycle operations. Shifts use a one-bit extension so the last bit
  // shifted out falls into the spare position (and stays 0 for amount 0).
  function automatic out_t calc(
    input logic [3:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    out_t             o;
    logic [WIDTH:0]   ext;
    logic [SHW-1:0]   sh;
    o   = '0;
    ext = '0;
    sh  = b[SHW-1:0];
    unique case (op)
      OP_ADD: begin
        ext   = {1'b0, a} + {1'b0, b};
        o.res = ext[WIDTH-1:0];
        o.c   = ext[WIDTH];
        o.v   = (a[WIDTH-1] == b[WIDTH-1])
              & (o.res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        o.res = a - b;
        o.c   = (a < b);
        o.v   = (a[WIDTH-1] != b[WIDTH-1])
              & (o.res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: o.res = a & b;
      OP_OR:  o.res = a | b;
      OP_XOR: o.res = a ^ b;
      OP_SLL: begin
        ext   = {1'b0, a} << sh;
        o.res = ext[WIDTH-1:0];
        o.c   = ext[WIDTH];
      end
      OP_SRL: begin
        ext   = {a, 1'b0} >> sh;
        o.res = ext[WIDTH:1];
        o.c   = ext[0];
      end
      OP_SRA: begin
        ext   = $unsigned($signed({a, 1'b0}) >>> sh);
        o.res = ext[WIDTH:1];
        o.c   = ext[0];
      end
      default: o.ill = 1'b1;
    endcase
    if (!o.ill) begin
      o.z = (o.res == '0);
      o.s = o.res[WIDTH-1];
    end
    // CMP reports flags of the difference but never writes a value back.
    if (op == OP_CMP) begin
      o.res = '0;
    end
    return o;
  endfunction

  assign alu_out = calc(opcode, A, B);

  assign acc_nxt = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    mul_out     = '0;
    mul_out.res = acc_nxt[WIDTH-1:0];
    mul_out.z   = (acc_nxt[WIDTH-1:0] == '0);
    mul_out.s   = acc_nxt[WIDTH-1];
    mul_out.c   = |acc_nxt[2*WIDTH-1:WIDTH];
    mul_out.v   = |acc_nxt[2*WIDTH-1:WIDTH];
  end

  assign in_ready = (state == IDLE)
                  || (state == DONE && out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_q     <= '0;
      out_valid <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      unique case (state)
        BUSY: begin
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          acc    <= acc_nxt;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            out_q     <= mul_out;
            out_valid <= 1'b1;
            cnt       <= '0;
            state     <= DONE;
          end
        end
        default: begin
          if (state == DONE && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
          if (accept) begin
            if (opcode == OP_MUL) begin
              mcand     <= {{WIDTH{1'b0}}, A};
              mplier    <= B;
              acc       <= '0;
              cnt       <= '0;
              out_valid <= 1'b0;
              state     <= BUSY;
            end else begin
              out_q     <= alu_out;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
      endcase
    end
  end

  assign result   = out_q.res;
  assign zero     = out_q.z;
  assign carry    = out_q.c;
  assign overflow = out_q.v;
  assign sign     = out_q.s;
  assign illegal  = out_q.ill;

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, registered ALU with a valid/ready handshake on input and output, and the full operation set. Adds shifts and an iterative unsigned multiply. Sits between the decode stage and the writeback stage of the core. It replaces the combinational single-cycle ALU so that operand width is configurable and multi-cycle operations can stall the pipeline cleanly.

## Interface
- WIDTH, 32, operand/result width; power of two, minimum 8.
- SHW, $clog2(WIDTH), derived localparam: shift-amount width.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request valid.
- in_ready  out  1  block can accept a request this cycle.
- opcode  in  4  operation select.
- A  in  WIDTH  first operand.
- B  in  WIDTH  second operand (shift amount = B[SHW-1:0]).
- out_valid  out  1  result/flags valid.
- out_ready  in  1  downstream consumes result this cycle.
- result  out  WIDTH  registered result.
- zero, carry, overflow, sign  out  1 each  registered flags.
- illegal  out  1  registered: opcode was unsupported.

## Operation
- Opcodes:
  - 0 ADD; 1 SUB; 2 AND; 3 OR; 4 XOR.
  - 5 CMP: A-B, result forced to 0, flags from the difference.
  - 6 SLL; 7 SRL; 8 SRA.
  - 9 MUL: unsigned, low WIDTH bits.
  - 10-15 illegal.
- Flags (result/diff = the WIDTH-bit value before CMP masking):
  - zero = (diff==0).
  - sign = diff[WIDTH-1].
  - ADD: carry = carry-out; overflow = signed overflow (operands same sign, result differs).
  - SUB/CMP: carry = borrow (A<B unsigned); overflow = (A,B differ in sign) and (result sign != A sign).
  - AND/OR/XOR: carry = overflow = 0.
  - Shifts: carry = last bit shifted out, 0 when amount = 0; overflow = 0. SRA fills with A[WIDTH-1].
  - MUL: carry = overflow = 1 iff the upper WIDTH bits of the 2*WIDTH product are nonzero.
  - Illegal: result = 0, all flags 0, illegal = 1.
- Transfer occurs on in_valid && in_ready (input) and out_valid && out_ready (output).
- FSM states IDLE, BUSY, DONE:
  - IDLE: accept → DONE (single-cycle ops), or → BUSY (MUL), loading multiplicand, multiplier and a zeroed 2*WIDTH accumulator.
  - BUSY: one shift-add step per cycle; bit counter counts 0..WIDTH-1. After the step with count = WIDTH-1, register result/flags → DONE.
  - DONE: out_valid = 1. On out_ready: if a new request is accepted the same cycle, go to DONE/BUSY for that request; otherwise → IDLE.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- Outputs are held stable while out_valid && !out_ready.
- Operands are captured at accept; A/B/opcode changes afterwards have no effect.

## Timing
- Reset (any state, including mid-MUL): state = IDLE, out_valid = 0, result = 0, all flags = 0, illegal = 0, counter = 0. In-flight op is discarded.
- Single-cycle ops: accepted at edge N → out_valid = 1 after edge N.
- Latency: 1 cycle for single-cycle ops, WIDTH+1 cycles for MUL.
- MUL: accepted at edge N → out_valid = 1 after edge N+WIDTH; in_ready = 0 throughout BUSY.
- Back-to-back single-cycle ops with out_ready held high: one result per cycle, no bubbles.
- Stall: with out_ready = 0 in DONE, in_ready = 0 and result/flags/out_valid hold.
- in_valid while in_ready = 0 is ignored. The requester must hold its request; the block does not latch it.

## Test plan
- Reset then ADD 0x7FFF_FFFF + 1 → after 1 cycle: result 0x8000_0000, overflow 1, sign 1, carry 0, zero 0.
- SUB 3-5 then CMP 5,5 back-to-back, out_ready = 1:
  - SUB → 0xFFFF_FFFE, carry (borrow) 1, sign 1.
  - CMP → result 0, zero 1, carry 0.
  - Results on consecutive cycles.
- SRA 0x8000_0001 by 1 → 0xC000_0000, carry 1. SLL by 0 → result = A, carry 0.
- MUL 7*6: out_valid exactly 33 cycles after accept, result 42, carry/overflow 0, in_ready = 0 while busy.
- MUL 0x0001_0000*0x0001_0000 → result 0, zero 1, carry = overflow = 1. Assert rst at cycle 10 of a second MUL → next cycle: IDLE, out_valid 0, all outputs 0.
- Opcode 12 → illegal 1, result 0, flags 0. Then hold out_ready = 0 for 5 cycles → outputs stable, in_ready = 0; release → IDLE.
